// File: rtl/lab6_iram_param_pkg.sv
// Shared definitions for the instruction RAM: loader FSM state encodings and the NOP word.
// Optional feature macro used by the design: IRAM_PARITY_EN.
package lab6_iram_param_pkg;

  typedef enum logic [1:0] {
    IRAM_IDLE = 2'd0,
    IRAM_LOAD = 2'd1,
    IRAM_FILL = 2'd2,
    IRAM_RUN  = 2'd3
  } iram_state_e;

  // Word written into every slot past the end of a loaded program.
  localparam int unsigned IRAM_NOP = 0;

endpackage

// File: rtl/iram_loader_fsm.sv
// Program-load sequencer: owns state, write pointer, LD_READY and BUSY, and
// tells the storage array when and where to write (load beat or NOP fill).
module iram_loader_fsm
  import lab6_iram_param_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_start_i,
  input  logic             ld_valid_i,
  input  logic             ld_last_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             we_o,
  output logic             fill_o,
  output logic             run_o,
  output logic             ld_ready_o,
  output logic             busy_o
);

  localparam logic [PTR_W-1:0] PtrMax = PTR_W'(DEPTH - 1);

  iram_state_e      state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             ld_ready_q;
  logic             busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IRAM_IDLE;
      ptr_q      <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IRAM_IDLE, IRAM_RUN: begin
          if (ld_start_i) begin
            state_q    <= IRAM_LOAD;
            ptr_q      <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        IRAM_LOAD: begin
          if (ld_valid_i) begin
            // A beat landing in the last slot fills memory: no NOP fill needed.
            if (ptr_q == PtrMax) begin
              state_q    <= IRAM_RUN;
              ld_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
              if (ld_last_i) begin
                state_q    <= IRAM_FILL;
                ld_ready_q <= 1'b0;
              end
            end
          end
        end
        IRAM_FILL: begin
          if (ptr_q == PtrMax) begin
            state_q <= IRAM_RUN;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= IRAM_IDLE;
      endcase
    end
  end

  assign ptr_o      = ptr_q;
  assign we_o       = ((state_q == IRAM_LOAD) && ld_valid_i) || (state_q == IRAM_FILL);
  assign fill_o     = (state_q == IRAM_FILL);
  assign run_o      = (state_q == IRAM_RUN);
  assign ld_ready_o = ld_ready_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/lab6_iram_param.sv
// Parameterised instruction RAM with streamed program load, NOP fill and registered fetch port.
// Define IRAM_PARITY_EN to add per-word even parity and the PERR output.
module lab6_iram_param
  import lab6_iram_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              REQ,
  output logic [DATA_W-1:0] Q,
  output logic              VALID,
  output logic              FERR,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
`ifdef IRAM_PARITY_EN
  output logic              PERR,
`endif
  output logic              BUSY
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Reset asserts asynchronously and releases on the first CLK edge after RESET_N rises.
  logic rst_sync_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;
  end

  logic [PTR_W-1:0] wr_ptr;
  logic             wr_en;
  logic             fill;
  logic             run;
  logic [DATA_W-1:0] wr_data;

  iram_loader_fsm #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_iram_loader_fsm (
    .clk_i      (CLK),
    .rst_ni     (rst_sync_q),
    .ld_start_i (LD_START),
    .ld_valid_i (LD_VALID),
    .ld_last_i  (LD_LAST),
    .ptr_o      (wr_ptr),
    .we_o       (wr_en),
    .fill_o     (fill),
    .run_o      (run),
    .ld_ready_o (LD_READY),
    .busy_o     (BUSY)
  );

  assign wr_data = fill ? DATA_W'(IRAM_NOP) : LD_DATA;

  // Storage is deliberately left out of reset so a reset never wipes the program.
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr] <= wr_data;
  end

  logic [ADDR_W-2:0] word_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              fetch_err;

  assign word_idx  = ADDR[ADDR_W-1:1];
  assign rd_idx    = word_idx[PTR_W-1:0];
  assign fetch_err = ADDR[0] | ({1'b0, word_idx} >= ADDR_W'(DEPTH));

`ifdef IRAM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q, perr_d;
  always_ff @(posedge CLK) begin
    if (wr_en) par_q[wr_ptr] <= ^wr_data;
  end
`endif

  logic [DATA_W-1:0] q_q, q_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    q_d     = q_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef IRAM_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (REQ && run) begin
      valid_d = 1'b1;
      if (fetch_err) begin
        ferr_d = 1'b0 | 1'b1;
        q_d    = '0;
      end else begin
        q_d = mem_q[rd_idx];
`ifdef IRAM_PARITY_EN
        perr_d = (^mem_q[rd_idx]) != par_q[rd_idx];
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef IRAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef IRAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
`ifdef IRAM_PARITY_EN
  assign PERR  = perr_q;
`endif

endmodule

// File: tb/tb_lab6_iram_param.sv
// Randomised self-checking bench for lab6_iram_param against a word-array program model;
// a second DEPTH=64 instance covers the out-of-range fetch error.
module tb_lab6_iram_param;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 8;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic          REQ = 1'b0;
  logic          LD_START = 1'b0;
  logic          ld_start64 = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_LAST = 1'b0;
  logic [DW-1:0] Q, q64;
  logic          VALID, FERR, LD_READY, BUSY;
  logic          valid64, ferr64, ld_ready64, busy64;
`ifdef IRAM_PARITY_EN
  logic          PERR, perr64;
`endif

  always #5 CLK = ~CLK;

  lab6_iram_param #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ADDR     (ADDR),
    .REQ      (REQ),
    .Q        (Q),
    .VALID    (VALID),
    .FERR     (FERR),
    .LD_START (LD_START),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_READY (LD_READY),
`ifdef IRAM_PARITY_EN
    .PERR     (PERR),
`endif
    .BUSY     (BUSY)
  );

  lab6_iram_param #(.DATA_W(DW), .DEPTH(64), .ADDR_W(AW)) dut64 (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ADDR     (ADDR),
    .REQ      (REQ),
    .Q        (q64),
    .VALID    (valid64),
    .FERR     (ferr64),
    .LD_START (ld_start64),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_READY (ld_ready64),
`ifdef IRAM_PARITY_EN
    .PERR     (perr64),
`endif
    .BUSY     (busy64)
  );

  // Program model: what each word should hold, whether fetches are served, last Q.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_run = 1'b0;
  logic [DW-1:0] exp_q = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load();
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    m_run = 1'b0;
    check("start_busy", 32'(BUSY), 32'd1);
    check("start_ld_ready", 32'(LD_READY), 32'd1);
  endtask

  task automatic run_beats(input int n, input bit use_last, input int mode, input bit mid_start,
                           input bit fixed);
    int acc = 0;
    int cyc = 0;
    logic [DW-1:0] d;
    while (acc < n && cyc < 4000) begin
      case (mode)
        0:       LD_VALID = 1'b1;
        1:       LD_VALID = (cyc % 2 == 0);
        default: LD_VALID = 1'($urandom_range(0, 1));
      endcase
      d = fixed ? DW'(32'h1111 * (acc + 1)) : DW'($urandom);
      LD_DATA  = d;
      LD_LAST  = use_last && (acc == n - 1);
      LD_START = mid_start && (acc == n / 2);
      REQ      = ($urandom_range(0, 3) == 0);
      ADDR     = AW'($urandom);
      check("ld_ready", 32'(LD_READY), 32'd1);
      check("busy_load", 32'(BUSY), 32'd1);
      tick();
      if (REQ) begin
        check("valid_busy", 32'(VALID), 32'd0);
        check("q_busy", 32'(Q), 32'(exp_q));
      end
      if (LD_VALID) begin
        m_mem[acc] = d;
        acc++;
      end
      cyc++;
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    LD_START = 1'b0;
    REQ      = 1'b0;
    if (acc < n) check("load_timeout", 32'(acc), 32'(n));
    check("ld_ready_off", 32'(LD_READY), 32'd0);
  endtask

  task automatic wait_fill(input int n);
    int cnt = 0;
    while (BUSY && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("fill_cycles", 32'(cnt), 32'(DEPTH - n));
    check("busy_done", 32'(BUSY), 32'd0);
    for (int i = n; i < DEPTH; i++) m_mem[i] = '0;
    m_run = 1'b1;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input bit chk64);
    logic          v_e, f_e;
    logic [DW-1:0] q_e;
    logic [AW-2:0] idx;
    idx  = a[AW-1:1];
    ADDR = a;
    REQ  = 1'b1;
    tick();
    REQ  = 1'b0;
    if (m_run) begin
      v_e = 1'b1;
      f_e = a[0] || (int'(idx) >= DEPTH);
      q_e = f_e ? '0 : m_mem[idx];
    end else begin
      v_e = 1'b0;
      f_e = 1'b0;
      q_e = exp_q;
    end
    exp_q = q_e;
    check("fetch_valid", 32'(VALID), 32'(v_e));
    check("fetch_ferr", 32'(FERR), 32'(f_e));
    check("fetch_q", 32'(Q), 32'(q_e));
    if (chk64) begin
      // The 64-word instance holds the first fixed 3-beat program followed by NOPs.
      f_e = a[0] || (int'(idx) >= 64);
      q_e = (f_e || idx >= 3) ? '0 : DW'(32'h1111 * (32'(idx) + 1));
      check("fetch64_valid", 32'(valid64), 32'd1);
      check("fetch64_ferr", 32'(ferr64), 32'(f_e));
      check("fetch64_q", 32'(q64), 32'(q_e));
    end
    tick();
    check("valid_pulse", 32'(VALID), 32'd0);
    check("ferr_pulse", 32'(FERR), 32'd0);
    check("q_hold", 32'(Q), 32'(exp_q));
  endtask

  task automatic random_fetches(input int k);
    for (int i = 0; i < k; i++) fetch(AW'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    int n;
    #12;
    check("rst_q", 32'(Q), 32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_ferr", 32'(FERR), 32'd0);
    check("rst_ld_ready", 32'(LD_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);

    // Release between edges with LD_START already high: LOAD only on the second edge.
    LD_START   = 1'b1;
    ld_start64 = 1'b1;
    RESET_N    = 1'b1;
    tick();
    check("rel_edge1_busy", 32'(BUSY), 32'd0);
    tick();
    check("rel_edge2_busy", 32'(BUSY), 32'd1);
    check("rel_edge2_ready", 32'(LD_READY), 32'd1);
    LD_START   = 1'b0;
    ld_start64 = 1'b0;
    m_run      = 1'b0;

    // Three fixed beats with LD_LAST, then 125 NOP fill cycles.
    run_beats(3, 1'b1, 0, 1'b0, 1'b1);
    wait_fill(3);
    fetch(8'd4, 1'b1);
    fetch(8'd6, 1'b1);
    fetch(8'd0, 1'b1);
    fetch(8'd3, 1'b1);
    fetch(8'd200, 1'b1);
    fetch(8'd130, 1'b1);

    // Full-depth load with no LD_LAST, started from RUN.
    start_load();
    run_beats(DEPTH, 1'b0, 2, 1'b0, 1'b0);
    wait_fill(DEPTH);
    fetch(8'd254, 1'b0);
    random_fetches(10);

    // Every-other-cycle LD_VALID with a stray LD_START in the middle.
    n = $urandom_range(4, 100);
    start_load();
    run_beats(n, 1'b1, 1, 1'b1, 1'b0);
    wait_fill(n);
    random_fetches(10);

    // Reset in the middle of FILL.
    fetch(8'd2, 1'b0);
    start_load();
    run_beats(2, 1'b1, 0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("midfill_busy", 32'(BUSY), 32'd1);
    RESET_N = 1'b0;
    #1;
    check("arst_q", 32'(Q), 32'd0);
    check("arst_valid", 32'(VALID), 32'd0);
    check("arst_ferr", 32'(FERR), 32'd0);
    check("arst_busy", 32'(BUSY), 32'd0);
    check("arst_ld_ready", 32'(LD_READY), 32'd0);
    m_run = 1'b0;
    exp_q = '0;
    #2;
    RESET_N = 1'b1;
    tick();
    tick();
    fetch(8'd4, 1'b0);
    fetch(8'd8, 1'b0);
    check("idle_busy", 32'(BUSY), 32'd0);

    // Fresh random load after the abandoned one.
    n = $urandom_range(1, DEPTH);
    start_load();
    run_beats(n, 1'b1, 2, 1'b0, 1'b0);
    wait_fill(n);
    random_fetches(10);

`ifdef IRAM_PARITY_EN
    dut.mem_q[2] = dut.mem_q[2] ^ 16'h0001;
    m_mem[2] = m_mem[2] ^ 16'h0001;
    ADDR = 8'd4;
    REQ  = 1'b1;
    tick();
    REQ  = 1'b0;
    exp_q = m_mem[2];
    check("perr_set", 32'(PERR), 32'd1);
    check("perr_valid", 32'(VALID), 32'd1);
    check("perr_q", 32'(Q), 32'(exp_q));
    tick();
    check("perr_pulse", 32'(PERR), 32'd0);
    fetch(8'd6, 1'b0);
    check("perr_clean", 32'(PERR), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
